parity_frame_checker: RTL

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

---
 rtl/parity_frame_checker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/parity_frame_checker.sv
// +---------------------------------------------------------------------------+
// | Module   : parity_frame_checker                                           |
// | Purpose  : Strobed serial frame receiver (start, DATA_W bits LSB first,   |
// |            parity, stop) with parity/framing flags and a one-deep output  |
// |            register using a valid/ready handshake.                        |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
`default_nettype none

module parity_frame_checker #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_perr,
    output logic              out_ferr,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned c_CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_DATA = 2'd1;
    localparam logic [1:0] c_ST_PAR  = 2'd2;
    localparam logic [1:0] c_ST_STOP = 2'd3;

    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par;
    logic               r_perr_pend;

    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_out_perr;
    logic               r_out_ferr;
    logic               r_overrun;

    logic [DATA_W-1:0]  w_shift_nxt;
    logic               w_complete;
    logic               w_accept;

    // Place the sampled bit at the position selected by the bit counter.
    always_comb begin
        w_shift_nxt = r_shift;
        for (int i = 0; i < DATA_W; i++) begin
            if (r_cnt == c_CNT_W'(i)) begin
                w_shift_nxt[i] = rx_bit;
            end
        end
    end

    assign w_complete = rx_en && (r_state == c_ST_STOP);
    assign w_accept   = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_perr_pend <= 1'b0;
        end else if (rx_en) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!rx_bit) begin
                        r_state <= c_ST_DATA;
                        r_cnt   <= '0;
                        r_par   <= 1'b0;
                        r_shift <= '0;
                    end
                end
                c_ST_DATA: begin
                    r_shift <= w_shift_nxt;
                    r_par   <= r_par ^ rx_bit;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_BIT) begin
                        r_state <= c_ST_PAR;
                    end
                end
                c_ST_PAR: begin
                    r_perr_pend <= r_par ^ rx_bit ^ PARITY_ODD;
                    r_state     <= c_ST_STOP;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // A completing frame is dropped, not stalled, when the held one is unconsumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_perr  <= 1'b0;
            r_out_ferr  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (w_accept) begin
                    r_out_data  <= r_shift;
                    r_out_perr  <= r_perr_pend;
                    r_out_ferr  <= ~rx_bit;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_perr  = r_out_perr;
    assign out_ferr  = r_out_ferr;
    assign overrun   = r_overrun;
    assign busy      = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire
